// File: rtl/dm_responder.sv
// dm_responder: data-memory end of the pipelined MIPS core's data port.
// Word-addressed RAM with byte-enable merge and a combinational read path.
// After reset the RAM is swept to zero. Committed stores push a
// (pc, word address, merged word) record into a small valid/ready trace FIFO.
module dm_responder #(
  parameter int WORDS      = 4096,
  parameter int IDX_W      = 12,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] m_data_addr,
  input  logic [31:0] m_data_wdata,
  input  logic [3:0]  m_data_byteen,
  input  logic [31:0] m_inst_addr,
  output logic [31:0] m_data_rdata,
  output logic        busy,
  output logic        trace_valid,
  input  logic        trace_ready,
  output logic [31:0] trace_pc,
  output logic [31:0] trace_addr,
  output logic [31:0] trace_data,
  output logic        trace_overflow
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_t;

  state_t             r_state;
  logic [IDX_W-1:0]   r_clearIdx;
  logic               r_busy;

  logic [31:0]        r_mem [WORDS];

  logic [31:0]        r_fifoPc   [FIFO_DEPTH];
  logic [31:0]        r_fifoAddr [FIFO_DEPTH];
  logic [31:0]        r_fifoData [FIFO_DEPTH];
  logic [PTR_W-1:0]   r_wrPtr;
  logic [PTR_W-1:0]   r_rdPtr;
  logic [CNT_W-1:0]   r_count;
  logic               r_overflow;

  logic [IDX_W-1:0]   w_idx;
  logic [31:0]        w_oldWord;
  logic [31:0]        w_merged;
  logic               w_store;
  logic               w_full;
  logic               w_pop;
  logic               w_pushOk;
  logic               w_drop;

  // Word index ignores the byte offset and any address bits above the RAM.
  assign w_idx     = m_data_addr[IDX_W+1:2];
  assign w_oldWord = r_mem[w_idx];
  assign w_store   = (r_state == ST_READY) && (|m_data_byteen);

  // Replace only the byte lanes the core enabled; keep the rest of the old word.
  always_comb begin
    w_merged = w_oldWord;
    for (int k = 0; k < 4; k++) begin
      if (m_data_byteen[k]) begin
        w_merged[8*k +: 8] = m_data_wdata[8*k +: 8];
      end
    end
  end

  // Clear sweep walks every word once after reset, then the block stays ready.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_CLEAR;
      r_clearIdx <= '0;
      r_busy     <= 1'b1;
    end else begin
      case (r_state)
        ST_CLEAR: begin
          r_clearIdx <= r_clearIdx + IDX_W'(1);
          if (r_clearIdx == {IDX_W{1'b1}}) begin
            r_state <= ST_READY;
            r_busy  <= 1'b0;
          end
        end
        ST_READY: begin
          r_state <= ST_READY;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= ST_CLEAR;
          r_busy  <= 1'b1;
        end
      endcase
    end
  end

  // RAM write port: zeros during the sweep, merged store words once ready.
  always_ff @(posedge clk) begin
    if (r_state == ST_CLEAR) begin
      r_mem[r_clearIdx] <= '0;
    end else if (w_store) begin
      r_mem[w_idx] <= w_merged;
    end
  end

  // Reads return zero until the sweep has finished so stale contents never leak.
  assign m_data_rdata = (r_state == ST_READY) ? w_oldWord : 32'h0;
  assign busy         = r_busy;

  assign w_full   = (r_count == CNT_W'(FIFO_DEPTH));
  assign w_pop    = (r_count != '0) && trace_ready;
  assign w_pushOk = w_store && (!w_full || w_pop);
  assign w_drop   = w_store && w_full && !w_pop;

  // Trace FIFO storage; a full FIFO still accepts a push when the head leaves this cycle.
  always_ff @(posedge clk) begin
    if (w_pushOk) begin
      r_fifoPc[r_wrPtr]   <= m_inst_addr;
      r_fifoAddr[r_wrPtr] <= m_data_addr & 32'hFFFF_FFFC;
      r_fifoData[r_wrPtr] <= w_merged;
    end
  end

  // FIFO pointers, occupancy and the sticky drop flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wrPtr    <= '0;
      r_rdPtr    <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_pushOk) begin
        r_wrPtr <= r_wrPtr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + PTR_W'(1);
      end
      case ({w_pushOk, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  assign trace_valid    = (r_count != '0);
  assign trace_pc       = r_fifoPc[r_rdPtr];
  assign trace_addr     = r_fifoAddr[r_rdPtr];
  assign trace_data     = r_fifoData[r_rdPtr];
  assign trace_overflow = r_overflow;

endmodule

// File: doc/dm_responder.md
Name: dm_responder

Overview:
- Synthesizable data-memory responder for the pipelined MIPS core: the memory end of the core's data port (m_data_addr / m_data_wdata / m_data_byteen in, m_data_rdata out).
- Provides word-addressed RAM with byte-enable merge and an asynchronous read path.
- Runs a post-reset clear sweep.
- Emits store-commit trace records (pc, word address, merged word) through a small valid/ready FIFO for an on-chip logger.

Parameters:
- WORDS, 4096, RAM depth in 32-bit words (power of two).
- IDX_W, 12, log2(WORDS); word index is m_data_addr[IDX_W+1:2].
- FIFO_DEPTH, 4, trace FIFO entries (power of two, >=2).

Ports:
- clk  input  1  single clock, all state on rising edge.
- reset  input  1  asynchronous, active-low reset.
- m_data_addr  input  32  byte address from core MEM stage.
- m_data_wdata  input  32  store data, byte lanes already aligned by core.
- m_data_byteen  input  4  per-byte write enable; 4'b0000 = no store.
- m_inst_addr  input  32  PC of instruction in MEM stage.
- m_data_rdata  output  32  read word at m_data_addr (combinational).
- busy  output  1  high while clear sweep in progress.
- trace_valid  output  1  FIFO head record available.
- trace_ready  input  1  consumer accepts head when high with trace_valid.
- trace_pc  output  32  head record PC.
- trace_addr  output  32  head record word address (low 2 bits 0).
- trace_data  output  32  head record merged word written.
- trace_overflow  output  1  sticky: a store record was dropped.

Behaviour:
- Reset (reset==0, asynchronous):
  - State goes to CLEAR and clear index to 0.
  - FIFO read/write pointers and count go to 0.
  - trace_valid=0, trace_overflow=0, busy=1.
  - RAM contents are not reset directly.
- FSM CLEAR:
  - Each cycle writes 0 to mem[clear_idx] and increments clear_idx.
  - After writing index WORDS-1, goes to READY on the next edge.
  - The sweep takes exactly WORDS cycles after reset release.
  - busy=1 throughout CLEAR.
  - m_data_rdata=0 during CLEAR.
  - Core stores during CLEAR are ignored: no RAM write, no trace push.
- FSM READY:
  - busy=0. No exit except reset.
- Read path:
  - m_data_rdata = mem[m_data_addr[IDX_W+1:2]], purely combinational, zero latency.
  - Address bits above IDX_W+1 are ignored, so addresses wrap modulo 4*WORDS.
  - Low 2 bits are ignored; the core performs byte/half extraction.
- Write path (READY and |m_data_byteen):
  - merged = old word with byte lane k replaced by m_data_wdata[8k+7:8k] where byteen[k]=1.
  - merged is written at the rising edge.
  - A read of the same word in the same cycle returns the old word; the new value is visible from the next cycle.
- Trace push:
  - Every committed write pushes {m_inst_addr, m_data_addr & 32'hFFFF_FFFC, merged}.
  - Pop occurs when trace_valid && trace_ready.
- Push rules:
  - Not full: push accepted.
  - Full with pop in the same cycle: push accepted, count unchanged.
  - Full with no pop: record dropped, trace_overflow set (sticky until reset). The RAM write still happens; the core is never stalled.
  - Empty with push: the record is visible on trace_* the next cycle. There is no bypass.
  - Simultaneous push and pop when not full or empty: count unchanged, pointers both advance.
- FIFO outputs:
  - trace_pc/addr/data reflect the head entry.
  - Values are don't-care while trace_valid=0.
  - Pointers wrap modulo FIFO_DEPTH.
- Reset mid-sweep or mid-stream: the sweep restarts from index 0 and all queued records are discarded.

Test Plan:
- Release reset (WORDS=4096) -> busy high for exactly 4096 cycles, then 0; reading any address afterwards returns 32'h0.
- During CLEAR, byteen=4'hF, addr 0x10, wdata 0xDEADBEEF -> after READY, rdata at 0x10 is 0; no trace_valid.
- READY: store word 0x11223344 at 0x20, then byteen=4'b0010 with wdata 0x0000AA00 at 0x21, pc 0x3008 -> rdata 0x1122AA44. Second trace record is pc 0x3008, addr 0x20, data 0x1122AA44.
- trace_ready=0, 5 stores (FIFO_DEPTH=4) -> trace_overflow=1 after 5th; raising ready pops the first 4 records in order; overflow stays 1.
- FIFO full, trace_ready=1 and store in same cycle -> push accepted, no overflow; trace order preserved.
- Address 0x4020 with WORDS=4096 -> aliases 0x0020 (same word read/written).
- Assert reset mid-sweep and with 2 queued records -> trace_valid drops immediately; full 4096-cycle sweep repeats; overflow cleared.
